// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory bus between the instruction-fetch port and the data port.
// One outstanding bus transaction at a time; each port sees a 2-bit status (10 = done pulse).
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic [1:0]        i_status,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic [1:0]        d_status,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

    localparam logic [1:0]  ST_IDLE = 2'b00;
    localparam logic [1:0]  ST_BUSY = 2'b01;
    localparam logic [1:0]  ST_DONE = 2'b10;
    localparam int          CNT_W   = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state, state_nxt;
    logic             owner_i;     // 1: the current/last bus transaction belongs to fetch
    logic             pulse;       // DONE carries a deliverable result
    logic             discard;     // result of the in-flight transaction must be dropped
    logic [CNT_W-1:0] starve_cnt;

    logic i_pulse, d_pulse, can_grant;
    logic fetch_wins, data_wins, grant_i, grant_d;
    logic ack, discard_now;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        i_pulse    = (state == DONE) && pulse && owner_i;
        d_pulse    = (state == DONE) && pulse && !owner_i;
        can_grant  = (state == IDLE) || (state == DONE);
        fetch_wins = i_req && (!d_req || (starve_cnt == LIMIT));
        data_wins  = d_req && !fetch_wins;
        // A port that just completed keeps its priority claim but cannot be re-granted
        // on its own pulse cycle; the grant then waits one cycle in IDLE.
        grant_i    = can_grant && fetch_wins && !i_pulse;
        grant_d    = can_grant && data_wins && !d_pulse;
        ack        = mem_req && mem_ack;
        // A redirected or abandoned request still lets the bus finish, but its result is dropped.
        discard_now = discard
                    || ((state == I_BUSY) && (!i_req || (i_addr != mem_addr)))
                    || ((state == D_BUSY) && !d_req);

        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (grant_i)      state_nxt = I_BUSY;
                else if (grant_d) state_nxt = D_BUSY;
                else              state_nxt = IDLE;
            end
            I_BUSY, D_BUSY: begin
                if (ack) state_nxt = discard_now ? IDLE : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status codes: reset forces 00 immediately, independent of the request levels.
    always_comb begin
        i_status = ST_IDLE;
        d_status = ST_IDLE;
        if (rst) begin
            if (i_pulse)                         i_status = ST_DONE;
            else if (i_req || state == I_BUSY)   i_status = ST_BUSY;
            if (d_pulse)                         d_status = ST_DONE;
            else if (d_req || state == D_BUSY)   d_status = ST_BUSY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner_i    <= 1'b0;
            pulse      <= 1'b0;
            discard    <= 1'b0;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;

            if (grant_i || grant_d) begin
                owner_i  <= grant_i;
                pulse    <= 1'b0;
                discard  <= 1'b0;
                mem_req  <= 1'b1;
                mem_we   <= grant_d && d_we;
                mem_addr <= grant_i ? i_addr : d_addr;
                if (grant_d) mem_wdata <= d_wdata;
            end else if (ack) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                pulse   <= !discard_now;
                discard <= 1'b0;
                if (!discard_now) begin
                    if (owner_i)      i_rdata <= mem_rdata;
                    else if (!mem_we) d_rdata <= mem_rdata;
                end
            end else if (state == I_BUSY || state == D_BUSY) begin
                discard <= discard_now;
            end

            if (!i_req || grant_i)                  starve_cnt <= '0;
            else if (grant_d && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
